// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder result path:
// default latency, error-flag bit positions and the stored result entry.
package adder_pkg;

    localparam int LATENCY  = 5;
    localparam int DATA_W   = 32;
    localparam int ERR_DROP = 0;
    localparam int ERR_SPUR = 1;

    typedef struct packed {
        logic              ovf;
        logic              carry;
        logic [DATA_W-1:0] data;
    } res_entry_t;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module result_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_din,
    input  logic             i_pop,
    output logic [W-1:0]     o_dout,
    output logic [CNT_W-1:0] o_level,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == CNT_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_drop  = i_push & ~w_push;
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + CNT_W'(1);
                2'b01:   r_level <= r_level - CNT_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/adder_result_collector.sv
// Collects the non-stallable adder result stream into a FIFO and hands
// out issue credits so that credited results always find a free slot.
module adder_result_collector
    import adder_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 8,
    parameter  int LATENCY = adder_pkg::LATENCY,
    localparam int CNT_W   = $clog2(DEPTH + LATENCY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ok,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_data,
    input  logic             res_carry,
    input  logic             res_ovf,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_carry,
    output logic             m_ovf,
    output logic [CNT_W-1:0] level,
    output logic [CNT_W-1:0] inflight,
    output logic [1:0]       err,
    input  logic             clr_err
);

    localparam int EW = WIDTH + 2;

    logic [CNT_W-1:0] r_inflight;
    logic [1:0]       r_err;
    logic [EW-1:0]    w_dout;
    logic [CNT_W:0]   w_occ;
    logic [1:0]       w_err_set;
    logic             w_empty;
    logic             w_full;
    logic             w_drop;
    logic             w_ret;
    logic             w_spur;
    logic             w_inc;

    result_fifo #(
        .W     (EW),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (res_valid),
        .i_din   ({res_ovf, res_carry, res_data}),
        .i_pop   (m_ready),
        .o_dout  (w_dout),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    assign m_valid = ~w_empty;
    assign {m_ovf, m_carry, m_data} = w_dout;

    // Credits count both stored and still-in-flight results.
    assign w_occ    = {1'b0, level} + {1'b0, r_inflight};
    assign issue_ok = (w_occ < (CNT_W+1)'(DEPTH));
    assign inflight = r_inflight;
    assign err      = r_err;

    assign w_ret  = res_valid & (r_inflight != '0);
    assign w_spur = res_valid & (r_inflight == '0);
    assign w_inc  = issue_valid & (~(&r_inflight) | w_ret);

    always_comb begin
        w_err_set           = '0;
        w_err_set[ERR_DROP] = w_drop;
        w_err_set[ERR_SPUR] = w_spur;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            unique case ({w_inc, w_ret})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_err <= '0;
        else if (clr_err) r_err <= '0;
        else              r_err <= r_err | w_err_set;
    end

    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_adder_result_collector.sv
// Randomized bench: an adder stand-in delays issues by LATENCY cycles and
// a queue-based model of the collector predicts every observable output.
module tb_adder_result_collector;
    import adder_pkg::*;

    localparam int DEPTH = 8;
    localparam int LAT   = 5;
    localparam int CNT_W = $clog2(DEPTH + LAT + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue_valid = 1'b0;
    logic             issue_ok;
    logic             res_valid = 1'b0;
    logic [DATA_W-1:0] res_data = '0;
    logic             res_carry = 1'b0;
    logic             res_ovf = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic             m_carry;
    logic             m_ovf;
    logic [CNT_W-1:0] level;
    logic [CNT_W-1:0] inflight;
    logic [1:0]       err;
    logic             clr_err = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    bit         pv [LAT];
    res_entry_t pd [LAT];

    res_entry_t mq [$];
    int         m_inf;
    logic [1:0] m_err;

    adder_result_collector dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ok    (issue_ok),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_carry   (res_carry),
        .res_ovf     (res_ovf),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_carry     (m_carry),
        .m_ovf       (m_ovf),
        .level       (level),
        .inflight    (inflight),
        .err         (err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    function automatic res_entry_t rand_entry();
        res_entry_t e;
        e.data  = $urandom;
        e.carry = 1'($urandom_range(0, 1));
        e.ovf   = 1'($urandom_range(0, 1));
        return e;
    endfunction

    function automatic logic [DATA_W+1:0] head();
        return {m_ovf, m_carry, m_data};
    endfunction

    // One clock: drive inputs, advance the model, clock, shift the adder pipe.
    task automatic tick(input bit iss, input res_entry_t e, input bit inj,
                        input bit rdy, input bit clr);
        bit rv, pop, psh, spur;
        res_entry_t r;
        rv = pv[LAT-1] | inj;
        r  = inj ? e : pd[LAT-1];
        issue_valid = iss;
        res_valid   = rv;
        res_data    = r.data;
        res_carry   = r.carry;
        res_ovf     = r.ovf;
        m_ready     = rdy;
        clr_err     = clr;
        pop  = (mq.size() != 0) && rdy;
        psh  = rv && (mq.size() < DEPTH || pop);
        spur = rv && (m_inf == 0);
        if (clr) m_err = 2'b00;
        else     m_err = m_err | {spur, rv && !psh};
        if (rv && m_inf > 0) m_inf--;
        if (iss) m_inf++;
        if (pop) void'(mq.pop_front());
        if (psh) mq.push_back(r);
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = iss;
        pd[0] = e;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(1'b0, rand_entry(), 1'b0, rdy, 1'b0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_inf = 0;
        m_err = 2'b00;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (level !== 0 || inflight !== 0 || err !== 2'b00 ||
            issue_ok !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: level=%0d inflight=%0d err=%b ok=%b mv=%b, need 0 0 00 1 0",
                     level, inflight, err, issue_ok, m_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(2, 1'b0);
        n_tests++;
        if (level !== 0 || inflight !== 0 || err !== 2'b00 ||
            issue_ok !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle: level=%0d inflight=%0d err=%b ok=%b mv=%b, need 0 0 00 1 0",
                     level, inflight, err, issue_ok, m_valid);
        end
    endtask

    task automatic test_single();
        res_entry_t e;
        e = '0;
        e.data = 32'h0000_0003;
        tick(1'b1, e, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (inflight !== 1 || m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_wait[%0d]: inflight=%0d mv=%b, need 1 0", i, inflight, m_valid);
            end
            if (i < 4) idle(1, 1'b1);
        end
        idle(1, 1'b0);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 32'h3 || m_carry !== 1'b0 ||
            m_ovf !== 1'b0 || inflight !== 0 || level !== 1) begin
            n_fail++;
            $display("FAIL single_out: mv=%b data=%h inflight=%0d level=%0d, need 1 3 0 1",
                     m_valid, m_data, inflight, level);
        end
        idle(1, 1'b1);
        n_tests++;
        if (level !== 0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: level=%0d mv=%b, need 0 0", level, m_valid);
        end
    endtask

    // Issue while the DUT grants credit, with the sink stalled.
    task automatic fill_under_credit(output int issued);
        bit ok_m;
        issued = 0;
        for (int i = 0; i < 20; i++) begin
            ok_m = (mq.size() + m_inf) < DEPTH;
            n_tests++;
            if (issue_ok !== ok_m) begin
                n_fail++;
                $display("FAIL credit_ok[%0d]: got=%b need=%b", i, issue_ok, ok_m);
            end
            if (issue_ok === 1'b1) issued++;
            tick(issue_ok === 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_credit();
        int issued;
        fill_under_credit(issued);
        n_tests++;
        if (issued !== 8 || level !== 8 || err !== 2'b00 ||
            inflight !== 0 || issue_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_fill: issued=%0d level=%0d err=%b inflight=%0d ok=%b, need 8 8 00 0 0",
                     issued, level, err, inflight, issue_ok);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (m_valid !== 1'b1 || head() !== mq[0]) begin
                n_fail++;
                $display("FAIL drain[%0d]: mv=%b head=%h need=%h", i, m_valid, head(), mq[0]);
            end
            tick(1'b0, rand_entry(), 1'b0, 1'b1, 1'b0);
        end
        n_tests++;
        if (level !== 0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_end: level=%0d mv=%b, need 0 0", level, m_valid);
        end
    endtask

    task automatic test_drop();
        int issued;
        fill_under_credit(issued);
        tick(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
        idle(6, 1'b0);
        n_tests++;
        if (err !== 2'b01 || level !== 8 || inflight !== 0) begin
            n_fail++;
            $display("FAIL drop: err=%b level=%0d inflight=%0d, need 01 8 0", err, level, inflight);
        end
        tick(1'b0, rand_entry(), 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (err !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_err: err=%b need 00", err);
        end
    endtask

    task automatic test_full_pushpop();
        res_entry_t e_new, oldest, second;
        logic [DATA_W+1:0] last;
        e_new  = rand_entry();
        oldest = mq[0];
        second = mq[1];
        tick(1'b1, e_new, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (pv[LAT-1]) begin
                n_tests++;
                if (head() !== oldest) begin
                    n_fail++;
                    $display("FAIL pushpop_head: got=%h need=%h", head(), oldest);
                end
            end
            tick(1'b0, rand_entry(), 1'b0, pv[LAT-1], 1'b0);
        end
        n_tests++;
        if (level !== 8 || err !== 2'b00 || head() !== second) begin
            n_fail++;
            $display("FAIL pushpop: level=%0d err=%b head=%h, need 8 00 %h",
                     level, err, head(), second);
        end
        last = '0;
        for (int i = 0; i < 8; i++) begin
            last = head();
            tick(1'b0, rand_entry(), 1'b0, 1'b1, 1'b0);
        end
        n_tests++;
        if (last !== e_new || level !== 0) begin
            n_fail++;
            $display("FAIL pushpop_tail: last=%h level=%0d, need %h 0", last, level, e_new);
        end
    endtask

    task automatic test_spurious();
        res_entry_t e;
        e = rand_entry();
        tick(1'b0, e, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (err !== 2'b10 || level !== 1 || inflight !== 0 || head() !== e) begin
            n_fail++;
            $display("FAIL spurious: err=%b level=%0d inflight=%0d head=%h, need 10 1 0 %h",
                     err, level, inflight, head(), e);
        end
        tick(1'b0, rand_entry(), 1'b0, 1'b1, 1'b1);
        n_tests++;
        if (err !== 2'b00 || level !== 0) begin
            n_fail++;
            $display("FAIL spur_clr: err=%b level=%0d, need 00 0", err, level);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            tick(1'b1, rand_entry(), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        idle(1, 1'b0);
        #2;
        issue_valid = 1'b0;
        res_valid   = 1'b0;
        m_ready     = 1'b0;
        clr_err     = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if (level !== 0 || inflight !== 0 || err !== 2'b00 ||
            issue_ok !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: level=%0d inflight=%0d err=%b ok=%b mv=%b, need 0 0 00 1 0",
                     level, inflight, err, issue_ok, m_valid);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(6, 1'b1);
        n_tests++;
        if (err !== 2'b10 || inflight !== 0) begin
            n_fail++;
            $display("FAIL post_reset_spur: err=%b inflight=%0d, need 10 0", err, inflight);
        end
        tick(1'b0, rand_entry(), 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        bit ok_m, iss;
        for (int c = 0; c < 400; c++) begin
            ok_m = (mq.size() + m_inf) < DEPTH;
            iss  = ok_m ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            tick(iss, rand_entry(), 1'b0, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 24) == 0));
            n_tests++;
            if (level !== CNT_W'(mq.size()) || inflight !== CNT_W'(m_inf) ||
                err !== m_err || m_valid !== (mq.size() != 0) ||
                issue_ok !== ((mq.size() + m_inf) < DEPTH) ||
                (mq.size() != 0 && head() !== mq[0])) begin
                n_fail++;
                $display("FAIL random[%0d]: level=%0d/%0d inflight=%0d/%0d err=%b/%b mv=%b ok=%b head=%h",
                         c, level, mq.size(), inflight, m_inf, err, m_err,
                         m_valid, issue_ok, head());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        model_reset();
        test_reset();
        test_single();
        test_credit();
        test_drop();
        test_full_pushpop();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_result_collector.md
Name: adder_result_collector

Overview:
- Receiving end of the pipelined adder's result stream.
- The adder has no backpressure: valid_out pulses exactly 5 cycles after valid_in, and results cannot be stalled.
- This block captures every result into a FIFO, presents it downstream on a ready/valid interface, and issues credits (issue_ok) to the operand source, so results issued under credit can never be dropped.

Parameters:
- WIDTH, 32, result data width.
- DEPTH, 8, FIFO entries (power of two, >= 2).
- LATENCY, 5, adder issue-to-result latency; bounds in-flight count.
- CNT_W, $clog2(DEPTH+LATENCY+1), width of level/inflight counters (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- issue_valid  in  1  copy of the adder's valid_in (one operation issued this cycle)
- issue_ok  out  1  credit available; source may issue this cycle
- res_valid  in  1  adder valid_out
- res_data  in  WIDTH  adder result
- res_carry  in  1  adder carry_out
- res_ovf  in  1  adder overflow
- m_valid  out  1  downstream data valid
- m_ready  in  1  downstream accept
- m_data  out  WIDTH  head result
- m_carry  out  1  head carry
- m_ovf  out  1  head overflow
- level  out  CNT_W  FIFO occupancy
- inflight  out  CNT_W  issued, not yet returned
- err  out  2  sticky: [0] drop (result arrived with FIFO full), [1] spurious (result with inflight==0)
- clr_err  in  1  synchronous clear of err

Behaviour:
- Reset (async, rst=1): level=0, inflight=0, err=0, read/write pointers=0, m_valid=0, issue_ok=1. FIFO storage is not reset. m_data/m_carry/m_ovf are don't-care while m_valid=0.
- issue_ok = (level + inflight) < DEPTH, decoded from registers only. It does not depend on issue_valid, res_valid or m_ready in the same cycle.
- inflight per cycle: +1 on issue_valid, -1 on res_valid with inflight>0. Both together: unchanged.
  - res_valid with inflight==0: inflight stays 0 (no underflow), err[1] set, result still stored if room.
- issue_valid while issue_ok=0 is not blocked. It is counted, and any later loss shows up as err[0].
- Push: res_valid=1 and (level<DEPTH or pop this cycle). Writes {res_ovf,res_carry,res_data} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop: m_valid & m_ready; rd_ptr advances modulo DEPTH.
- Push while full with no pop: result discarded, err[0] set, level stays DEPTH.
- Simultaneous push+pop: level unchanged, both pointers advance. When full, the freed slot is reused the same cycle.
- m_valid = (level != 0). m_data/m_carry/m_ovf = entry at rd_ptr (first-word-fall-through). A result pushed into an empty FIFO appears one cycle later.
- Latency res_valid to m_valid: 1 cycle when empty.
- m_data must not change while m_valid=1 and m_ready=0.
- err bits are sticky until clr_err=1. clr_err has priority over a same-cycle set: the bit reads 0 next cycle, and the new event is lost.
- Reset mid-operation: all counters and flags return to reset values immediately. In-flight results arriving afterwards count as spurious (err[1]).

Decomposition:
- Shared package adder_pkg: LATENCY default 5, err bit indices (ERR_DROP=0, ERR_SPUR=1), packed result-entry typedef {ovf, carry, data}.
- One sub-module: result_fifo (storage, pointers, level, full/empty).
- Credit and in-flight tracking plus error flags stay in the top module.

Test Plan:
- Reset then idle -> issue_ok=1, m_valid=0, level=0, inflight=0, err=0.
- Issue 1 op (result 0x0000_0003, carry 0, ovf 0) with m_ready=1 -> inflight 1 for 5 cycles, m_valid=1 one cycle after res_valid with m_data=0x3, then level=0.
- m_ready=0, issue back-to-back under credit -> exactly 8 issued before issue_ok=0 (level+inflight=8). All 8 stored in order, err=0. Then m_ready=1 drains them in order.
- Force 9th issue while issue_ok=0, m_ready=0 -> 9th result discarded, err=2'b01, level=8. clr_err -> err=0.
- FIFO full, res_valid and m_ready in same cycle -> level stays 8, new entry stored, popped entry is the oldest.
- res_valid with inflight=0 -> err[1]=1, entry stored, inflight stays 0. Assert rst mid-burst -> all counters 0 immediately, issue_ok=1.
